instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction queue plus issue FSM that turns 64-bit
// instructions into single-cycle buffer/accumulator command pulses.
// Optional feature: define INSTR_ILLEGAL_CHECK_EN to raise a sticky
// err_illegal flag when an unknown opcode is popped. Without it, unknown
// opcodes behave as NOPs and err_illegal stays 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | queue empty or just refilled; no command issued this cycle
// S_ISSUE   | pop and decode one queued instruction per cycle
// S_COMPUTE | hold state_signal=10 for C+1 cycles; pop blocked until done
module instr_sequencer #(
    parameter int ADDR_W     = 7,
    parameter int OBUF_AW    = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [63:0]         instruction,
    output logic                instr_ready,
    output logic [ADDR_W-1:0]   inp_buf_addr,
    output logic [DATA_W-1:0]   inp_buf_data,
    output logic                inp_buf_we,
    output logic [ADDR_W-1:0]   wt_buf_addr,
    output logic [DATA_W-1:0]   wt_buf_data,
    output logic                wt_buf_we,
    output logic [OBUF_AW-1:0]  acc_to_op_buf_addr,
    output logic                acc_result_to_op_buf,
    output logic [OBUF_AW-1:0]  out_buf_addr,
    output logic                op_buffer_instr_for_sending_data,
    output logic                instr_for_accum_to_reset,
    output logic [1:0]          state_signal,
    output logic                i_mode,
    output logic                busy,
    output logic                err_illegal
);

    localparam int ENTRY_W = 5 + ADDR_W + DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_COMPUTE = 2'b10
    } state_t;

    state_t              state;
    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic [7:0]          cyc_left;

    logic                push;
    logic                pop;
    logic                do_issue;
    logic                stay_compute;
    logic [ENTRY_W-1:0]  head;
    logic [4:0]          head_op;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                head_compute;

    // Instruction bits above the data field carry nothing for this block.
    generate
        if (ENTRY_W < 64) begin : g_unused
            logic unused_instr_bits;
            assign unused_instr_bits = ^instruction[63:ENTRY_W];
        end
    endgenerate

    // Handshake, issue decision and head-of-queue field extraction.
    always_comb begin
        push         = instr_valid && instr_ready;
        stay_compute = (state == S_COMPUTE) && (cyc_left != 8'd0);
        // The last compute cycle doubles as an issue slot so the next
        // command follows with no gap.
        do_issue     = (state == S_ISSUE) || ((state == S_COMPUTE) && (cyc_left == 8'd0));
        pop          = do_issue && (count != '0);
        head         = fifo_mem[rd_ptr];
        head_op      = head[4:0];
        head_addr    = head[5 +: ADDR_W];
        head_data    = head[5 + ADDR_W +: DATA_W];
        head_compute = (head_op == 5'b00001) || (head_op == 5'b00010);
        count_next   = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Instruction queue: circular buffer with an occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= instruction[ENTRY_W-1:0];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // Sequencer FSM with registered command outputs (pulses default to 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                            <= S_IDLE;
            cyc_left                         <= 8'd0;
            instr_ready                      <= 1'b0;
            busy                             <= 1'b0;
            err_illegal                      <= 1'b0;
            state_signal                     <= 2'b00;
            i_mode                           <= 1'b0;
            inp_buf_addr                     <= '0;
            inp_buf_data                     <= '0;
            inp_buf_we                       <= 1'b0;
            wt_buf_addr                      <= '0;
            wt_buf_data                      <= '0;
            wt_buf_we                        <= 1'b0;
            acc_to_op_buf_addr               <= '0;
            acc_result_to_op_buf             <= 1'b0;
            out_buf_addr                     <= '0;
            op_buffer_instr_for_sending_data <= 1'b0;
            instr_for_accum_to_reset         <= 1'b0;
        end else begin
            state_signal                     <= 2'b00;
            i_mode                           <= 1'b0;
            inp_buf_addr                     <= '0;
            inp_buf_data                     <= '0;
            inp_buf_we                       <= 1'b0;
            wt_buf_addr                      <= '0;
            wt_buf_data                      <= '0;
            wt_buf_we                        <= 1'b0;
            acc_to_op_buf_addr               <= '0;
            acc_result_to_op_buf             <= 1'b0;
            out_buf_addr                     <= '0;
            op_buffer_instr_for_sending_data <= 1'b0;
            instr_for_accum_to_reset         <= 1'b0;

            // Ready is a registered !full, so a pop never frees a slot for a
            // push in the same cycle.
            instr_ready <= (count_next != CNT_W'(FIFO_DEPTH));
            busy        <= (count_next != '0) || (pop && head_compute) || stay_compute;

            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE, S_COMPUTE: begin
                    if (stay_compute) begin
                        cyc_left     <= cyc_left - 8'd1;
                        state_signal <= 2'b10;
                        i_mode       <= i_mode;
                    end else if (!pop) begin
                        state <= S_IDLE;
                    end else begin
                        state <= (count_next != '0) ? S_ISSUE : S_IDLE;
                        case (head_op)
                            5'b00001, 5'b00010: begin
                                state        <= S_COMPUTE;
                                cyc_left     <= head_data[7:0];
                                state_signal <= 2'b10;
                                i_mode       <= head_op[1];
                            end
                            5'b00011: begin
                                state_signal         <= 2'b01;
                                acc_to_op_buf_addr   <= head_addr[OBUF_AW-1:0];
                                acc_result_to_op_buf <= 1'b1;
                            end
                            5'b00100: begin
                                state_signal <= 2'b01;
                                inp_buf_addr <= head_addr;
                                inp_buf_data <= head_data;
                                inp_buf_we   <= 1'b1;
                            end
                            5'b00101: begin
                                state_signal <= 2'b01;
                                wt_buf_addr  <= head_addr;
                                wt_buf_data  <= head_data;
                                wt_buf_we    <= 1'b1;
                            end
                            5'b00110: begin
                                out_buf_addr                     <= head_addr[OBUF_AW-1:0];
                                op_buffer_instr_for_sending_data <= 1'b1;
                            end
                            5'b00111: begin
                                instr_for_accum_to_reset <= 1'b1;
                            end
                            5'b00000, 5'b11111: begin
                            end
                            default: begin
`ifdef INSTR_ILLEGAL_CHECK_EN
                                err_illegal <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed scenarios plus a randomized stream
// checked against a timestamped transaction model of the issue schedule.
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int ADDR_W  = 7;
    localparam int OBUF_AW = 4;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
`ifdef INSTR_ILLEGAL_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                instr_valid = 1'b0;
    logic [63:0]         instruction = 64'd0;
    logic                instr_ready;
    logic [ADDR_W-1:0]   inp_buf_addr;
    logic [DATA_W-1:0]   inp_buf_data;
    logic                inp_buf_we;
    logic [ADDR_W-1:0]   wt_buf_addr;
    logic [DATA_W-1:0]   wt_buf_data;
    logic                wt_buf_we;
    logic [OBUF_AW-1:0]  acc_to_op_buf_addr;
    logic                acc_result_to_op_buf;
    logic [OBUF_AW-1:0]  out_buf_addr;
    logic                op_buffer_instr_for_sending_data;
    logic                instr_for_accum_to_reset;
    logic [1:0]          state_signal;
    logic                i_mode;
    logic                busy;
    logic                err_illegal;

    typedef struct packed {
        logic [1:0]  ss;
        logic        im;
        logic        iwe;
        logic [6:0]  ia;
        logic [31:0] id;
        logic        wwe;
        logic [6:0]  wa;
        logic [31:0] wd;
        logic        ae;
        logic [3:0]  aa;
        logic        oe;
        logic [3:0]  oa;
        logic        ar;
    } out_t;

    out_t obs;
    assign obs = {state_signal, i_mode, inp_buf_we, inp_buf_addr, inp_buf_data,
                  wt_buf_we, wt_buf_addr, wt_buf_data, acc_result_to_op_buf,
                  acc_to_op_buf_addr, op_buffer_instr_for_sending_data, out_buf_addr,
                  instr_for_accum_to_reset};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: every accepted instruction gets an issue cycle and an
    // output window; expected outputs are looked up by cycle number.
    out_t exp_tab [int];
    bit   comp_tab [int];
    int   pend [$];
    int   last_end = -100;
    int   err_edge = -1;
    bit   m_ready  = 1'b0;
    out_t exp_o;
    bit   exp_busy;
    bit   exp_err;

    instr_sequencer #(
        .ADDR_W(ADDR_W), .OBUF_AW(OBUF_AW), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instruction(instruction), .instr_ready(instr_ready),
        .inp_buf_addr(inp_buf_addr), .inp_buf_data(inp_buf_data), .inp_buf_we(inp_buf_we),
        .wt_buf_addr(wt_buf_addr), .wt_buf_data(wt_buf_data), .wt_buf_we(wt_buf_we),
        .acc_to_op_buf_addr(acc_to_op_buf_addr), .acc_result_to_op_buf(acc_result_to_op_buf),
        .out_buf_addr(out_buf_addr),
        .op_buffer_instr_for_sending_data(op_buffer_instr_for_sending_data),
        .instr_for_accum_to_reset(instr_for_accum_to_reset),
        .state_signal(state_signal), .i_mode(i_mode), .busy(busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic bit is_comp(input logic [4:0] op);
        return (op == 5'd1) || (op == 5'd2);
    endfunction

    function automatic bit is_illegal(input logic [4:0] op);
        return (op >= 5'd8) && (op <= 5'd30);
    endfunction

    function automatic out_t decode(input logic [4:0] op, input logic [6:0] ad, input logic [31:0] dt);
        out_t e = '0;
        case (op)
            5'd1, 5'd2: begin e.ss = 2'b10; e.im = (op == 5'd2); end
            5'd3: begin e.ss = 2'b01; e.ae = 1'b1; e.aa = ad[3:0]; end
            5'd4: begin e.ss = 2'b01; e.iwe = 1'b1; e.ia = ad; e.id = dt; end
            5'd5: begin e.ss = 2'b01; e.wwe = 1'b1; e.wa = ad; e.wd = dt; end
            5'd6: begin e.oe = 1'b1; e.oa = ad[3:0]; end
            5'd7: begin e.ar = 1'b1; end
            default: begin end
        endcase
        return e;
    endfunction

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [6:0] ad, input logic [31:0] dt);
        return {20'd0, dt, ad, op};
    endfunction

    function automatic logic [63:0] rand_instr();
        logic [4:0]  op;
        logic [31:0] d;
        case ($urandom_range(0, 9))
            0: op = 5'd0;
            1: op = 5'd31;
            2: op = 5'd3;
            3: op = 5'd4;
            4: op = 5'd5;
            5: op = 5'd6;
            6: op = 5'd7;
            7: op = 5'd1;
            8: op = 5'd2;
            default: op = 5'($urandom_range(8, 30));
        endcase
        d = $urandom;
        if (is_comp(op)) d[7:0] = 8'($urandom_range(0, 4));
        return {20'($urandom), d, 7'($urandom), op};
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_tab.delete();
        comp_tab.delete();
        last_end = -100;
        err_edge = -1;
        m_ready  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, return at negedge.
    task automatic tick(input logic v, input logic [63:0] ins);
        logic [4:0]  op;
        logic [6:0]  ad;
        logic [31:0] dt;
        int          s;
        int          len;
        out_t        e;
        instr_valid = v;
        instruction = ins;
        @(posedge clk);
        cyc++;
        if (v && m_ready) begin
            op  = ins[4:0];
            ad  = ins[11:5];
            dt  = ins[43:12];
            s   = (cyc <= last_end) ? last_end + 1 : cyc + 2;
            len = is_comp(op) ? int'(dt[7:0]) + 1 : 1;
            e   = decode(op, ad, dt);
            for (int k = 0; k < len; k++) begin
                exp_tab[s + k] = e;
                if (is_comp(op)) comp_tab[s + k] = 1'b1;
            end
            last_end = s + len - 1;
            pend.push_back(s);
            if (is_illegal(op) && err_edge < 0) err_edge = s;
        end
        while (pend.size() != 0 && pend[0] <= cyc) pend.delete(0);
        m_ready  = (pend.size() != DEPTH);
        exp_o    = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
        exp_busy = (pend.size() != 0) || comp_tab.exists(cyc);
        exp_err  = ERR_EN && (err_edge >= 0) && (cyc >= err_edge);
        if (exp_tab.exists(cyc)) exp_tab.delete(cyc);
        if (comp_tab.exists(cyc)) comp_tab.delete(cyc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 64'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", instr_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
        rst_n = 1'b1;
        tick(1'b0, 64'd0);
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", instr_ready); end
        total++; if (obs !== '0) begin bad++; $display("FAIL release_outputs got=%h exp=0", obs); end
    endtask

    task automatic test_inp_write();
        idle(40);
        tick(1'b1, mk(5'd4, 7'd5, 32'hDEAD_BEEF));
        total++; if (inp_buf_we !== 1'b0) begin bad++; $display("FAIL inp_we_E got=%b exp=0", inp_buf_we); end
        tick(1'b0, 64'd0);
        total++; if (inp_buf_we !== 1'b0) begin bad++; $display("FAIL inp_we_E1 got=%b exp=0", inp_buf_we); end
        tick(1'b0, 64'd0);
        total++; if (inp_buf_we !== 1'b1) begin bad++; $display("FAIL inp_we_E2 got=%b exp=1", inp_buf_we); end
        total++; if (inp_buf_addr !== 7'd5) begin bad++; $display("FAIL inp_addr got=%0d exp=5", inp_buf_addr); end
        total++; if (inp_buf_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL inp_data got=%h exp=deadbeef", inp_buf_data); end
        total++; if (state_signal !== 2'b01) begin bad++; $display("FAIL inp_state got=%b exp=01", state_signal); end
        tick(1'b0, 64'd0);
        total++; if (obs !== '0) begin bad++; $display("FAIL inp_after got=%h exp=0", obs); end
    endtask

    task automatic test_compute_then_wt();
        logic [31:0] wd;
        wd = $urandom;
        idle(40);
        tick(1'b1, mk(5'd2, 7'd0, 32'd3));
        tick(1'b1, mk(5'd5, 7'd2, wd));
        total++; if (state_signal !== 2'b00) begin bad++; $display("FAIL cw_pre_state got=%b exp=00", state_signal); end
        for (int j = 2; j <= 7; j++) begin
            tick(1'b0, 64'd0);
            if (j <= 5) begin
                total++;
                if (state_signal !== 2'b10 || i_mode !== 1'b1 || wt_buf_we !== 1'b0) begin
                    bad++; $display("FAIL cw_compute j=%0d got ss=%b im=%b we=%b exp ss=10 im=1 we=0", j, state_signal, i_mode, wt_buf_we);
                end
            end else if (j == 6) begin
                total++;
                if (wt_buf_we !== 1'b1 || wt_buf_addr !== 7'd2 || wt_buf_data !== wd || state_signal !== 2'b01 || i_mode !== 1'b0) begin
                    bad++; $display("FAIL cw_wt got we=%b addr=%0d data=%h ss=%b exp we=1 addr=2 data=%h ss=01", wt_buf_we, wt_buf_addr, wt_buf_data, state_signal, wd);
                end
            end else begin
                total++; if (obs !== '0) begin bad++; $display("FAIL cw_after got=%h exp=0", obs); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dat [6];
        logic [6:0]  got_a [$];
        logic [31:0] got_d [$];
        logic        exp_r;
        int          first;
        first = -1;
        idle(40);
        tick(1'b1, mk(5'd1, 7'd0, 32'd10));
        idle(2);
        for (int k = 0; k < 6; k++) begin
            dat[k] = $urandom;
            tick(1'b1, mk(5'd4, 7'(k), dat[k]));
            exp_r = (k < 3);
            total++; if (instr_ready !== exp_r) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, instr_ready, exp_r); end
            total++; if (state_signal !== 2'b10) begin bad++; $display("FAIL b2b_hold k=%0d got=%b exp=10", k, state_signal); end
        end
        for (int t = 1; t <= 30; t++) begin
            tick(1'b0, 64'd0);
            if (inp_buf_we === 1'b1) begin
                got_a.push_back(inp_buf_addr);
                got_d.push_back(inp_buf_data);
                if (first < 0) first = t;
            end
        end
        total++; if (got_a.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got_a.size()); end
        total++; if (first != 5) begin bad++; $display("FAIL b2b_first got=%0d exp=5", first); end
        for (int k = 0; k < got_a.size() && k < 4; k++) begin
            total++;
            if (got_a[k] !== 7'(k) || got_d[k] !== dat[k]) begin
                bad++; $display("FAIL b2b_order k=%0d got addr=%0d data=%h exp addr=%0d data=%h", k, got_a[k], got_d[k], k, dat[k]);
            end
        end
    endtask

    task automatic test_illegal();
        idle(40);
        tick(1'b1, mk(5'b01010, 7'd3, $urandom));
        tick(1'b0, 64'd0);
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL ill_early got=%b exp=0", err_illegal); end
        for (int j = 0; j < 4; j++) begin
            tick(1'b0, 64'd0);
            total++; if (err_illegal !== ERR_EN) begin bad++; $display("FAIL ill_err j=%0d got=%b exp=%b", j, err_illegal, ERR_EN); end
            total++; if (obs !== '0) begin bad++; $display("FAIL ill_outputs j=%0d got=%h exp=0", j, obs); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 2) != 0), rand_instr());
            total++; if (obs !== exp_o) begin bad++; $display("FAIL rnd_outputs cyc=%0d got=%h exp=%h", cyc, obs, exp_o); end
            total++; if (instr_ready !== m_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, instr_ready, m_ready); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            total++; if (err_illegal !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_illegal, exp_err); end
        end
    endtask

    task automatic test_reset_in_compute();
        idle(40);
        tick(1'b1, mk(5'd1, 7'd0, 32'd5));
        tick(1'b1, mk(5'd4, 7'd9, 32'h1234_5678));
        idle(2);
        total++; if (state_signal !== 2'b10) begin bad++; $display("FAIL rc_pre got=%b exp=10", state_signal); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL rc_async_outputs got=%h exp=0", obs); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rc_busy got=%b exp=0", busy); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL rc_ready got=%b exp=0", instr_ready); end
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL rc_err got=%b exp=0", err_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int t = 1; t <= 12; t++) begin
            tick(1'b0, 64'd0);
            total++; if (obs !== '0) begin bad++; $display("FAIL rc_after t=%0d got=%h exp=0", t, obs); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rc_after_busy t=%0d got=%b exp=0", t, busy); end
            total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rc_after_ready t=%0d got=%b exp=1", t, instr_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_inp_write();
        test_compute_then_wt();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_in_compute();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
